// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM states, timeout
// default and the MEM/WB boundary payload.
package mem_pkg;

    localparam int unsigned XLEN                 = 64;
    localparam int unsigned REG_AW               = 5;
    localparam int unsigned CNT_W                = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF   = 255;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [XLEN-1:0]   read_data;
        logic [XLEN-1:0]   alu_result;
        logic [REG_AW-1:0] rd;
    } mem_wb_t;

    // Doubleword accesses need the three low address bits clear.
    function automatic logic is_dword_aligned(input logic [XLEN-1:0] addr);
        return (addr[2:0] == 3'b000);
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: plain synchronous-reset, load-enabled payload store.
module mem_wb_reg
    import mem_pkg::*;
(
    input  logic    clk,
    input  logic    reset_i,
    input  logic    load_i,
    input  mem_wb_t d_i,
    output mem_wb_t q_o
);

    mem_wb_t payload_q;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            payload_q <= '0;
        end else if (load_i) begin
            payload_q <= d_i;
        end
    end

    assign q_o = payload_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues data-memory loads/stores over req/ack, stalls upstream while
// an access is outstanding and feeds the MEM/WB boundary register.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned ADDR_W         = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [XLEN-1:0]   AluOut,
    input  logic [XLEN-1:0]   DataOut,
    input  logic [REG_AW-1:0] Rd_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              mem_fault,
    output logic              RegWrite_wb,
    output logic              MemtoReg_wb,
    output logic [XLEN-1:0]   ReadData_wb,
    output logic [XLEN-1:0]   AluResult_wb,
    output logic [REG_AW-1:0] Rd_wb
);

    // Last WAIT cycle index before the access is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              fault_q, fault_d;
    logic              stall_c;
    mem_wb_t           wb_d, wb_q;

    logic access;
    logic aligned;

    assign access  = MemRead | MemWrite;
    assign aligned = is_dword_aligned(AluOut);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fault_d = 1'b0;
        stall_c = 1'b0;

        // Default: the current instruction flows into MEM/WB, read data held.
        wb_d.reg_write  = RegWrite;
        wb_d.mem_to_reg = MemtoReg;
        wb_d.read_data  = wb_q.read_data;
        wb_d.alu_result = AluOut;
        wb_d.rd         = Rd_in;

        unique case (state_q)
            IDLE: begin
                if (access) begin
                    if (!aligned) begin
                        fault_d        = 1'b1;
                        wb_d.reg_write = 1'b0;
                    end else begin
                        stall_c        = 1'b1;
                        addr_d         = AluOut[ADDR_W-1:0];
                        wdata_d        = DataOut;
                        we_d           = MemWrite;
                        cnt_d          = '0;
                        state_d        = WAIT;
                        wb_d.reg_write = 1'b0;
                    end
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    if (!we_q) begin
                        wb_d.read_data = mem_rdata;
                    end
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d        = 1'b1;
                    wb_d.reg_write = 1'b0;
                    state_d        = IDLE;
                end else begin
                    stall_c        = 1'b1;
                    cnt_d          = cnt_q + CNT_W'(1);
                    wb_d.reg_write = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_d = (state_d == WAIT);
    end

    mem_wb_reg u_mem_wb_reg (
        .clk     (clk),
        .reset_i (reset),
        .load_i  (1'b1),
        .d_i     (wb_d),
        .q_o     (wb_q)
    );

    assign stall        = stall_c & ~reset;
    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_fault    = fault_q;
    assign RegWrite_wb  = wb_q.reg_write;
    assign MemtoReg_wb  = wb_q.mem_to_reg;
    assign ReadData_wb  = wb_q.read_data;
    assign AluResult_wb = wb_q.alu_result;
    assign Rd_wb        = wb_q.rd;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, reset-in-WAIT
// sequence and randomized instruction stream against a transaction-level model.
module tb_mem_access_stage;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite, MemtoReg, MemWrite, MemRead;
    logic [63:0] AluOut, DataOut;
    logic [4:0]  Rd_in;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack, stall, mem_fault;
    logic        RegWrite_wb, MemtoReg_wb;
    logic [63:0] ReadData_wb, AluResult_wb;
    logic [4:0]  Rd_wb;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] rd_model = '0;

    typedef struct {
        logic        rw, mt, mr, mw;
        logic [63:0] alu, dout;
        logic [4:0]  rd;
        int          ack_at;
        logic        stray;
        logic [63:0] rdata;
        int          exp_stalls, exp_reqs;
        logic        exp_fault, exp_rw;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t tbl[10];

    mem_access_stage #(.TIMEOUT_CYCLES(TMO), .ADDR_W(64)) dut (
        .clk(clk), .reset(reset),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .MemRead(MemRead),
        .AluOut(AluOut), .DataOut(DataOut), .Rd_in(Rd_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .mem_fault(mem_fault),
        .RegWrite_wb(RegWrite_wb), .MemtoReg_wb(MemtoReg_wb), .ReadData_wb(ReadData_wb),
        .AluResult_wb(AluResult_wb), .Rd_wb(Rd_wb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rw, input logic mt, input logic mr, input logic mw,
                                input logic [63:0] alu, input logic [63:0] dout, input logic [4:0] rd,
                                input int ack_at, input logic stray, input logic [63:0] rdata,
                                input int es, input int er, input logic ef, input logic erw,
                                input logic [63:0] erd);
        vec_t v;
        v.rw = rw; v.mt = mt; v.mr = mr; v.mw = mw; v.alu = alu; v.dout = dout; v.rd = rd;
        v.ack_at = ack_at; v.stray = stray; v.rdata = rdata;
        v.exp_stalls = es; v.exp_reqs = er; v.exp_fault = ef; v.exp_rw = erw; v.exp_rdata = erd;
        return v;
    endfunction

    // Transaction-level expectation: what one instruction should cost and leave in MEM/WB.
    function automatic vec_t model(input vec_t v, input logic [63:0] prev_rd);
        vec_t r = v;
        r.exp_rdata = prev_rd;
        r.exp_stalls = 0; r.exp_reqs = 0; r.exp_fault = 1'b0; r.exp_rw = v.rw;
        if (v.mr || v.mw) begin
            if (v.alu[2:0] != 3'b000) begin
                r.exp_fault = 1'b1; r.exp_rw = 1'b0;
            end else if (v.ack_at <= TMO) begin
                r.exp_stalls = v.ack_at; r.exp_reqs = v.ack_at;
                if (!v.mw) r.exp_rdata = v.rdata;
            end else begin
                r.exp_stalls = TMO; r.exp_reqs = TMO;
                r.exp_fault = 1'b1; r.exp_rw = 1'b0;
            end
        end
        return r;
    endfunction

    // Runs one instruction from issue to completion; entered and left at posedge+1.
    task automatic run_instr(input vec_t v);
        int   waits, stalls, reqs, cyc;
        logic stall_s, done;
        RegWrite = v.rw; MemtoReg = v.mt; MemRead = v.mr; MemWrite = v.mw;
        AluOut = v.alu; DataOut = v.dout; Rd_in = v.rd;
        waits = 0; stalls = 0; reqs = 0; cyc = 0; done = 1'b0;
        while (!done) begin
            mem_rdata = {$urandom, $urandom};
            if (mem_req) begin
                waits++; reqs++;
                chk("mem_addr", mem_addr, v.alu);
                chk("mem_we", 64'(mem_we), 64'(v.mw));
                chk("mem_wdata", mem_wdata, v.dout);
                mem_ack = (waits == v.ack_at);
                if (mem_ack) mem_rdata = v.rdata;
            end else begin
                mem_ack = v.stray;
            end
            #3;
            stall_s = stall;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            cyc++;
            if (stall_s) begin
                stalls++;
                chk("bubble_regwrite", 64'(RegWrite_wb), 64'd0);
                chk("bubble_readdata", ReadData_wb, rd_model);
                chk("bubble_fault", 64'(mem_fault), 64'd0);
            end else begin
                done = 1'b1;
            end
            if (cyc > TMO + 3) begin
                n_checks++; n_errors++;
                $display("FAIL completion_budget: still stalled after %0d cycles", cyc);
                done = 1'b1;
            end
        end
        chk("stall_cycles", 64'(stalls), 64'(v.exp_stalls));
        chk("req_cycles", 64'(reqs), 64'(v.exp_reqs));
        chk("mem_fault", 64'(mem_fault), 64'(v.exp_fault));
        chk("mem_req_after", 64'(mem_req), 64'd0);
        chk("RegWrite_wb", 64'(RegWrite_wb), 64'(v.exp_rw));
        chk("MemtoReg_wb", 64'(MemtoReg_wb), 64'(v.mt));
        chk("AluResult_wb", AluResult_wb, v.alu);
        chk("Rd_wb", 64'(Rd_wb), 64'(v.rd));
        chk("ReadData_wb", ReadData_wb, v.exp_rdata);
        rd_model = v.exp_rdata;
    endtask

    task automatic set_nop();
        RegWrite = 1'b0; MemtoReg = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        AluOut = '0; DataOut = '0; Rd_in = '0;
    endtask

    task automatic chk_wb_zero(input string tag);
        chk({tag, "_RegWrite_wb"}, 64'(RegWrite_wb), 64'd0);
        chk({tag, "_MemtoReg_wb"}, 64'(MemtoReg_wb), 64'd0);
        chk({tag, "_ReadData_wb"}, ReadData_wb, 64'd0);
        chk({tag, "_AluResult_wb"}, AluResult_wb, 64'd0);
        chk({tag, "_Rd_wb"}, 64'(Rd_wb), 64'd0);
    endtask

    initial begin
        vec_t v;
        //           rw mt mr mw alu            dout   rd ack stray rdata                    st rq f  rw rdata
        tbl[0] = mk(1, 0, 0, 0, 64'h2A,        64'h0,  5, 1, 0, 64'h0,                   0, 0, 0, 1, 64'h0);
        tbl[1] = mk(1, 1, 1, 0, 64'h100,       64'h0,  7, 3, 0, 64'hDEADBEEF,            3, 3, 0, 1, 64'hDEADBEEF);
        tbl[2] = mk(0, 0, 0, 1, 64'h208,       64'h55, 0, 1, 1, 64'h1111,                1, 1, 0, 0, 64'hDEADBEEF);
        tbl[3] = mk(1, 1, 1, 0, 64'h103,       64'h0,  3, 1, 1, 64'h2222,                0, 0, 1, 0, 64'hDEADBEEF);
        tbl[4] = mk(1, 1, 1, 0, 64'h300,       64'h0,  4, 5, 0, 64'h3333,                4, 4, 1, 0, 64'hDEADBEEF);
        tbl[5] = mk(1, 0, 0, 0, 64'h7,         64'h0,  9, 1, 1, 64'h0,                   0, 0, 0, 1, 64'hDEADBEEF);
        tbl[6] = mk(1, 0, 1, 1, 64'h400,       64'hAA, 2, 2, 0, 64'h9999,                2, 2, 0, 1, 64'hDEADBEEF);
        tbl[7] = mk(1, 1, 1, 0, 64'h500,       64'h0, 31, 4, 0, 64'h0123456789ABCDEF,    4, 4, 0, 1, 64'h0123456789ABCDEF);
        tbl[8] = mk(0, 0, 0, 1, 64'h604,       64'h77, 0, 1, 0, 64'h0,                   0, 0, 1, 0, 64'h0123456789ABCDEF);
        tbl[9] = mk(1, 1, 1, 0, 64'hFFFFFFF8,  64'h0, 12, 1, 0, 64'hCAFE,                1, 1, 0, 1, 64'hCAFE);

        reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        set_nop();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_mem_req", 64'(mem_req), 64'd0);
        chk("reset_mem_we", 64'(mem_we), 64'd0);
        chk("reset_mem_addr", mem_addr, 64'd0);
        chk("reset_mem_wdata", mem_wdata, 64'd0);
        chk("reset_mem_fault", 64'(mem_fault), 64'd0);
        chk_wb_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_instr(tbl[i]);

        // Reset while waiting on the second WAIT cycle, then a late ack.
        RegWrite = 1'b1; MemtoReg = 1'b1; MemRead = 1'b1; MemWrite = 1'b0;
        AluOut = 64'h800; DataOut = '0; Rd_in = 5'd9; mem_ack = 1'b0;
        @(posedge clk); #1;
        chk("rst_wait1_req", 64'(mem_req), 64'd1);
        @(posedge clk); #1;
        chk("rst_wait2_req", 64'(mem_req), 64'd1);
        reset = 1'b1;
        #3;
        chk("rst_wait_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        chk("rst_wait_req_drop", 64'(mem_req), 64'd0);
        chk("rst_wait_fault", 64'(mem_fault), 64'd0);
        chk_wb_zero("rst_wait");
        reset = 1'b0;
        set_nop();
        mem_ack = 1'b1; mem_rdata = 64'h1234;
        #3;
        chk("late_ack_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("late_ack_req", 64'(mem_req), 64'd0);
        chk("late_ack_readdata", ReadData_wb, 64'd0);
        chk("late_ack_regwrite", 64'(RegWrite_wb), 64'd0);
        rd_model = '0;

        for (int n = 0; n < 300; n++) begin
            v.rw = 1'($urandom_range(1, 0));
            v.mt = 1'($urandom_range(1, 0));
            v.mr = 1'($urandom_range(1, 0));
            v.mw = 1'($urandom_range(3, 0) == 0);
            v.alu = {$urandom, $urandom};
            if ($urandom_range(3, 0) != 0) v.alu[2:0] = 3'b000;
            v.dout = {$urandom, $urandom};
            v.rd = 5'($urandom_range(31, 0));
            v.ack_at = int'($urandom_range(TMO + 1, 1));
            v.stray = 1'($urandom_range(1, 0));
            v.rdata = {$urandom, $urandom};
            run_instr(model(v, rd_model));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 64-bit pipeline. It consumes the EX/MEM register outputs and runs data-memory loads/stores over a req/ack handshake.
- Holds the pipeline with a stall while an access is outstanding.
- Registers results into the MEM/WB boundary, which the writeback mux consumes.
- Non-memory instructions pass through in one cycle. Memory instructions take at least two cycles.

Parameters:
- TIMEOUT_CYCLES, 255: cycles spent in WAIT without mem_ack before the access is aborted; must be 1..255.
- ADDR_W, 64: width of the memory address bus (low ADDR_W bits of the ALU result).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- RegWrite  in  1  from EX/MEM
- MemtoReg  in  1  from EX/MEM
- MemWrite  in  1  from EX/MEM
- MemRead  in  1  from EX/MEM
- AluOut  in  64  address or ALU result
- DataOut  in  64  store data
- Rd_in  in  5  destination register
- mem_req  out  1  request valid
- mem_we  out  1  1=store, 0=load
- mem_addr  out  ADDR_W  doubleword-aligned address
- mem_wdata  out  64  store data
- mem_rdata  in  64  load data, valid with mem_ack
- mem_ack  in  1  single-cycle completion
- stall  out  1  freeze PC/IF/ID/EX/EX-MEM this cycle
- mem_fault  out  1  one-cycle pulse: misaligned address or timeout
- RegWrite_wb  out  1  MEM/WB
- MemtoReg_wb  out  1  MEM/WB
- ReadData_wb  out  64  MEM/WB
- AluResult_wb  out  64  MEM/WB
- Rd_wb  out  5  MEM/WB

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_fault=0; all *_wb outputs 0; timeout counter 0. stall=0 while reset is high.
- Reset mid-WAIT: mem_req drops on the next edge. A late mem_ack is ignored.
- Access definition: access = MemRead | MemWrite. If both are set, MemWrite wins.
- Alignment: aligned = (AluOut[2:0] == 0).
- IDLE, access=0:
  - stall=0.
  - At the edge, MEM/WB captures RegWrite, MemtoReg, AluOut, Rd_in. ReadData_wb is unchanged.
- IDLE, access=1, aligned=0:
  - No request is issued; stall=0.
  - At the edge, mem_fault pulses 1 for one cycle. MEM/WB captures the instruction with RegWrite_wb forced to 0.
- IDLE, access=1, aligned=1:
  - stall=1.
  - At the edge, latch mem_addr=AluOut[ADDR_W-1:0], mem_wdata=DataOut, mem_we=MemWrite; clear the counter; go to WAIT.
  - MEM/WB gets a bubble (RegWrite_wb=0).
- WAIT:
  - mem_req=1; address, data and we are stable.
  - mem_ack=0: stall=1, counter increments, MEM/WB gets a bubble.
  - mem_ack=1: stall=0. At the edge, MEM/WB captures RegWrite, MemtoReg, AluOut, Rd_in, and ReadData_wb=mem_rdata for loads (unchanged for stores). mem_req drops; return to IDLE.
  - Counter reaches TIMEOUT_CYCLES with no ack: stall=0. At the edge, mem_fault pulses, MEM/WB gets the instruction with RegWrite_wb=0, mem_req drops, return to IDLE.
- Ack outside WAIT is ignored.
- Latency: non-memory 1 cycle; memory access 1 + N cycles, where N is the number of WAIT cycles up to and including the ack.
- Upstream hold: the EX/MEM inputs must stay stable while stall=1. The hazard unit uses stall to gate every upstream register enable.
- Back-to-back accesses: the cycle after an ack sits in IDLE with the next instruction. No idle gap is required beyond the IDLE issue cycle.

Decomposition:
- Package mem_pkg holds:
  - state enum {IDLE, WAIT};
  - the TIMEOUT_CYCLES default;
  - a struct for the MEM/WB payload (RegWrite, MemtoReg, ReadData, AluResult, Rd).
- One sub-module, mem_wb_reg: a plain reset/load register for the payload. Bubble insertion is done by the parent through the RegWrite_in=0 select.

Test Plan:
- ALU op: RegWrite=1, AluOut=0x2A, Rd=5, no access → stall stays 0; next cycle RegWrite_wb=1, AluResult_wb=0x2A, Rd_wb=5.
- Load: MemRead=1, AluOut=0x100, mem_ack on the 3rd WAIT cycle with rdata=0xDEADBEEF → stall=1 for 3 cycles, mem_addr=0x100, mem_we=0; then ReadData_wb=0xDEADBEEF with RegWrite_wb=1; bubbles in between.
- Store: MemWrite=1, AluOut=0x208, DataOut=0x55, ack in the first WAIT cycle → mem_we=1, mem_wdata=0x55 for one req cycle; total stall 1 cycle.
- Misaligned: MemRead=1, AluOut=0x103 → no mem_req; mem_fault pulses once; RegWrite_wb=0.
- Timeout: TIMEOUT_CYCLES=4, load with no ack → mem_req high for exactly 4 cycles, then mem_fault pulses and RegWrite_wb=0; a later stray ack is ignored.
- Reset in WAIT: assert reset on the 2nd WAIT cycle → next edge mem_req=0, all *_wb=0, state IDLE; an ack in the following cycle has no effect.
